// File: rtl/des_pkg.sv
// Shared DES tables and helpers for the round function f(R,K) = P(S(E(R) ^ K)).
// Bit vectors use ascending ranges: index 0 is DES bit 1 (the MSB).
package des_pkg;

  localparam int DES_HALF_W = 32;
  localparam int DES_KEY_W  = 48;

  // Expansion and permutation tables hold 1-based DES bit positions.
  localparam int DES_E [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int DES_P [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each box is addressed by row*16 + col.
  localparam int DES_SBOX [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
  };

  function automatic logic [0:DES_KEY_W-1] des_e(input logic [0:DES_HALF_W-1] r);
    logic [0:DES_KEY_W-1] e;
    for (int i = 0; i < DES_KEY_W; i++) e[i] = r[DES_E[i]-1];
    return e;
  endfunction

  function automatic logic [0:DES_HALF_W-1] des_p(input logic [0:DES_HALF_W-1] s);
    logic [0:DES_HALF_W-1] p;
    for (int i = 0; i < DES_HALF_W; i++) p[i] = s[DES_P[i]-1];
    return p;
  endfunction

endpackage

// File: rtl/des_sbox.sv
// One combinational 6->4 DES S-box; IDX selects S1..S8 (0..7).
module des_sbox
  import des_pkg::*;
#(
  parameter int IDX = 0
) (
  input  logic [0:5] in_b,
  output logic [0:3] out_s
);

  logic [5:0] addr;

  generate
    if (IDX < 0 || IDX > 7) begin : g_bad_idx
      $error("des_sbox: IDX must be 0..7");
    end
  endgenerate

  // Outer bits pick the row, inner four bits pick the column.
  assign addr  = {in_b[0], in_b[5], in_b[1:4]};
  assign out_s = 4'(DES_SBOX[IDX][addr]);

endmodule

// File: rtl/des_f_pipe.sv
// Pipelined DES round function f(R,K) with valid/ready flow control and a tag sideband.
// Define DES_F_SKID_EN to add a 2-entry output skid buffer that makes in_ready a register.
module des_f_pipe
  import des_pkg::*;
#(
  parameter int PIPE_STAGES = 3,
  parameter int TAG_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:DES_HALF_W-1] in_r,
  input  logic [0:DES_KEY_W-1]  in_k,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:DES_HALF_W-1] out_f,
  output logic [TAG_W-1:0]      out_tag
);

  generate
    if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
      $error("des_f_pipe: PIPE_STAGES must be 1..3");
    end
  endgenerate

  logic                   adv;
  logic                   accept;
  logic [PIPE_STAGES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_d [PIPE_STAGES];
  logic [0:DES_KEY_W-1]   mix;
  logic [0:DES_KEY_W-1]   sbox_in;
  logic [0:DES_HALF_W-1]  sbox_out;
  logic [0:DES_HALF_W-1]  f_q, f_d;
  logic                   fin_valid;
  logic [TAG_W-1:0]       fin_tag;

  // in_ready always equals adv, so an accepted beat implies the pipeline shifts.
  assign accept    = in_valid & in_ready;
  assign mix       = des_e(in_r) ^ in_k;
  assign fin_valid = valid_q[PIPE_STAGES-1];
  assign fin_tag   = tag_q[PIPE_STAGES-1];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (adv) begin
      valid_d[0] = accept;
      if (accept) tag_d[0] = in_tag;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) tag_d[i] = tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) tag_q[i] <= '0;
      f_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      f_q     <= f_d;
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_sbox
    des_sbox #(.IDX(gi)) u_sbox (
      .in_b  (sbox_in[gi*6 +: 6]),
      .out_s (sbox_out[gi*4 +: 4])
    );
  end

  generate
    if (PIPE_STAGES == 1) begin : g_s1
      assign sbox_in = mix;
      always_comb begin
        f_d = f_q;
        if (accept) f_d = des_p(sbox_out);
      end
    end else begin : g_s23
      logic [0:DES_KEY_W-1] mix_q, mix_d;

      always_comb begin
        mix_d = mix_q;
        if (accept) mix_d = mix;
      end

      always_ff @(posedge clk) begin
        if (rst) mix_q <= '0;
        else     mix_q <= mix_d;
      end

      assign sbox_in = mix_q;

      if (PIPE_STAGES == 2) begin : g_s2
        always_comb begin
          f_d = f_q;
          if (adv && valid_q[0]) f_d = des_p(sbox_out);
        end
      end else begin : g_s3
        logic [0:DES_HALF_W-1] sub_q, sub_d;

        always_comb begin
          sub_d = sub_q;
          if (adv && valid_q[0]) sub_d = sbox_out;
        end

        always_ff @(posedge clk) begin
          if (rst) sub_q <= '0;
          else     sub_q <= sub_d;
        end

        always_comb begin
          f_d = f_q;
          if (adv && valid_q[1]) f_d = des_p(sub_q);
        end
      end
    end
  endgenerate

`ifdef DES_F_SKID_EN
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            cnt_keep;
  logic                  in_ready_q, in_ready_d;
  logic [0:DES_HALF_W-1] skid_f_q [2];
  logic [0:DES_HALF_W-1] skid_f_d [2];
  logic [TAG_W-1:0]      skid_tag_q [2];
  logic [TAG_W-1:0]      skid_tag_d [2];
  logic                  push, pop;

  // The pipeline only moves while the skid can take whatever leaves the last stage.
  assign adv       = in_ready_q;
  assign in_ready  = in_ready_q;
  assign push      = adv & fin_valid;
  assign pop       = out_valid & out_ready;
  assign out_valid = (cnt_q != 2'd0);
  assign out_f     = skid_f_q[0];
  assign out_tag   = skid_tag_q[0];

  always_comb begin
    skid_f_d   = skid_f_q;
    skid_tag_d = skid_tag_q;
    cnt_keep   = cnt_q - {1'b0, pop};
    if (pop) begin
      skid_f_d[0]   = skid_f_q[1];
      skid_tag_d[0] = skid_tag_q[1];
    end
    if (push) begin
      skid_f_d[cnt_keep[0]]   = f_q;
      skid_tag_d[cnt_keep[0]] = fin_tag;
    end
    cnt_d      = cnt_keep + {1'b0, push};
    in_ready_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        skid_f_q[i]   <= '0;
        skid_tag_q[i] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      skid_f_q   <= skid_f_d;
      skid_tag_q <= skid_tag_d;
    end
  end
`else
  assign adv       = !fin_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = fin_valid;
  assign out_f     = f_q;
  assign out_tag   = fin_tag;
`endif

endmodule

// File: tb/tb_des_f_pipe.sv
// Directed self-checking bench for des_f_pipe; expected f values come from a local DES model.
// Build with or without DES_F_SKID_EN; PIPE_STAGES may be overridden to sweep 1..3.
module tb_des_f_pipe;
  parameter int PIPE_STAGES = 3;
`ifdef DES_F_SKID_EN
  localparam int LAT = PIPE_STAGES + 1;
`else
  localparam int LAT = PIPE_STAGES;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_r, out_f;
  logic [47:0] in_k;
  logic [3:0]  in_tag, out_tag;

  int n_cmp = 0;
  int n_bad = 0;

  logic        s_acc, s_ov, s_ir;
  logic [31:0] s_of;
  logic [3:0]  s_ot;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  des_f_pipe #(.PIPE_STAGES(PIPE_STAGES), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_k(in_k), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f), .out_tag(out_tag)
  );

  localparam int TB_E [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                               16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int TB_P [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int TB_SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  // Model works on [31:0]/[47:0] words: DES bit n of a W-bit word lives at index W-n.
  function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e, x;
    logic [31:0] s, f;
    logic [5:0]  six;
    int          row, col;
    for (int i = 0; i < 48; i++) e[47-i] = r[32-TB_E[i]];
    x = e ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      row = 2 * int'(six[5]) + int'(six[0]);
      col = int'(six[4:1]);
      s[31-4*b -: 4] = 4'(TB_SB[b][row*16+col]);
    end
    for (int i = 0; i < 32; i++) f[31-i] = s[32-TB_P[i]];
    return f;
  endfunction

  // Drive one cycle's inputs at the falling edge, then sample what the next rising edge will see.
  task automatic cyc(input logic iv, input logic [31:0] r, input logic [47:0] k,
                     input logic [3:0] t, input logic ordy);
    @(negedge clk);
    in_valid = iv; in_r = r; in_k = k; in_tag = t; out_ready = ordy;
    #1;
    s_ir  = in_ready;
    s_acc = iv & in_ready;
    s_ov  = out_valid;
    s_of  = out_f;
    s_ot  = out_tag;
    if (s_acc) exp_q.push_back({model_f(r, k), t});
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_r = '0; in_k = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
    n_cmp++; if (out_f !== 32'h0) begin n_bad++; $display("FAIL reset_f: got %h, expected 0", out_f); end
    n_cmp++; if (out_tag !== 4'h0) begin n_bad++; $display("FAIL reset_tag: got %h, expected 0", out_tag); end
    rst = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_known();
    int lat = -1;
    exp_q.delete();
    cyc(1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072, 4'd3, 1'b1);
    n_cmp++; if (s_acc !== 1'b1) begin n_bad++; $display("FAIL known_accept: got %b, expected 1", s_acc); end
    for (int step = 1; step <= LAT + 4 && lat < 0; step++) begin
      cyc(1'b0, 32'h0, 48'h0, 4'h0, 1'b1);
      if (s_ov) begin
        lat = step;
        n_cmp++; if (s_of !== 32'h234AA9BB) begin n_bad++; $display("FAIL known_f: got %h, expected 234aa9bb", s_of); end
        n_cmp++; if (s_ot !== 4'd3) begin n_bad++; $display("FAIL known_tag: got %0d, expected 3", s_ot); end
      end
    end
    n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL known_latency: got %0d, expected %0d", lat, LAT); end
    cyc(1'b0, 32'h0, 48'h0, 4'h0, 1'b1);
    n_cmp++; if (s_ov !== 1'b0) begin n_bad++; $display("FAIL known_single: out_valid %b after delivery, expected 0", s_ov); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [47:0] k;
    logic [35:0] exp;
    logic        sending;
    int sent = 0, got = 0, first = -1;
    exp_q.delete();
    r = $urandom; k = {16'($urandom), $urandom};
    for (int step = 0; step < 16 + LAT + 8 && got < 16; step++) begin
      sending = (sent < 16);
      cyc(sending, r, k, 4'(sent), 1'b1);
      if (sending) begin
        n_cmp++; if (s_acc !== 1'b1) begin n_bad++; $display("FAIL stream_accept beat %0d: in_ready %b, expected 1", sent, s_ir); end
        if (s_acc) begin sent++; r = $urandom; k = {16'($urandom), $urandom}; end
      end
      if (s_ov) begin
        if (first < 0) first = step;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL stream_extra: got f=%h tag=%0d, expected no output", s_of, s_ot);
        end else begin
          exp = exp_q.pop_front();
          if ({s_of, s_ot} !== exp || s_ot !== 4'(got) || step != first + got)
            begin n_bad++; $display("FAIL stream_beat %0d: got f=%h tag=%0d step=%0d, expected f=%h tag=%0d step=%0d",
                                     got, s_of, s_ot, step, exp[35:4], got, first + got); end
        end
        got++;
      end
    end
    n_cmp++; if (got != 16) begin n_bad++; $display("FAIL stream_count: got %0d, expected 16", got); end
    n_cmp++; if (first != LAT) begin n_bad++; $display("FAIL stream_latency: got %0d, expected %0d", first, LAT); end
  endtask

  task automatic test_backpressure();
    logic [31:0] r, hf;
    logic [47:0] k;
    logic [35:0] exp;
    logic [3:0]  ht;
    logic        ordy, stalled, ir1;
    int sent = 0, got = 0;
    stalled = 1'b0; hf = '0; ht = '0;
    exp_q.delete();
    r = $urandom; k = {16'($urandom), $urandom};
    for (int step = 0; step < 300 && got < 20; step++) begin
      ordy = (step % 4 == 0) || (step % 4 == 3);
      cyc(sent < 20, r, k, 4'(sent), ordy);
      if (stalled) begin
        n_cmp++;
        if (s_ov !== 1'b1 || s_of !== hf || s_ot !== ht) begin n_bad++;
          $display("FAIL bp_hold: got v=%b f=%h tag=%0d, expected v=1 f=%h tag=%0d", s_ov, s_of, s_ot, hf, ht); end
      end
      stalled = s_ov & ~ordy; hf = s_of; ht = s_ot;
`ifdef DES_F_SKID_EN
      out_ready = ~ordy; #1; ir1 = in_ready; out_ready = ordy; #1;
      n_cmp++; if (ir1 !== s_ir) begin n_bad++; $display("FAIL bp_in_ready_comb: in_ready went %b to %b with out_ready", s_ir, ir1); end
`else
      ir1 = ~s_ov | ordy;
      n_cmp++; if (s_ir !== ir1) begin n_bad++; $display("FAIL bp_in_ready: got %b, expected %b", s_ir, ir1); end
`endif
      if (s_acc) begin sent++; r = $urandom; k = {16'($urandom), $urandom}; end
      if (s_ov && ordy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL bp_extra: got f=%h tag=%0d, expected no output", s_of, s_ot);
        end else begin
          exp = exp_q.pop_front();
          if ({s_of, s_ot} !== exp) begin n_bad++;
            $display("FAIL bp_beat %0d: got f=%h tag=%0d, expected f=%h tag=%0d", got, s_of, s_ot, exp[35:4], exp[3:0]); end
        end
        got++;
      end
    end
    n_cmp++; if (got != 20 || exp_q.size() != 0) begin n_bad++;
      $display("FAIL bp_count: got %0d outputs with %0d pending, expected 20 with 0", got, exp_q.size()); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 48'h0, 4'h0, 1'b1);
      n_cmp++; if (s_ov !== 1'b0) begin n_bad++; $display("FAIL bp_duplicate: got out_valid %b, expected 0", s_ov); end
    end
  endtask

  task automatic test_reset_midflight();
    int acc_n = 0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, $urandom, {16'($urandom), $urandom}, 4'(8 + i), 1'b0);
      if (s_acc) acc_n++;
    end
    n_cmp++; if (acc_n < 1) begin n_bad++; $display("FAIL rstmid_accept: got %0d accepts, expected at least 1", acc_n); end
    @(negedge clk); rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); rst = 1'b0; out_ready = 1'b1; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b, expected 0", out_valid); end
    n_cmp++; if (out_f !== 32'h0) begin n_bad++; $display("FAIL rstmid_f: got %h, expected 0", out_f); end
    n_cmp++; if (out_tag !== 4'h0) begin n_bad++; $display("FAIL rstmid_tag: got %h, expected 0", out_tag); end
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 32'h0, 48'h0, 4'h0, 1'b1);
      n_cmp++; if (s_ov !== 1'b0) begin n_bad++; $display("FAIL rstmid_ghost: got out_valid %b tag=%0d, expected 0", s_ov, s_ot); end
    end
  endtask

  task automatic test_bubbles();
    logic        iv_hist [32];
    logic        ov_hist [32];
    logic [35:0] exp;
    exp_q.delete();
    for (int s = 0; s < 32; s++) begin
      cyc((s < 12) && (s % 2 == 0), $urandom, {16'($urandom), $urandom}, 4'(s), 1'b1);
      iv_hist[s] = (s < 12) && (s % 2 == 0);
      ov_hist[s] = s_ov;
      if (s_ov) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL bubble_extra: got f=%h tag=%0d, expected no output", s_of, s_ot);
        end else begin
          exp = exp_q.pop_front();
          if ({s_of, s_ot} !== exp) begin n_bad++;
            $display("FAIL bubble_data step %0d: got f=%h tag=%0d, expected f=%h tag=%0d", s, s_of, s_ot, exp[35:4], exp[3:0]); end
        end
      end
    end
    for (int s = 0; s < 12; s++) begin
      n_cmp++; if (ov_hist[s+LAT] !== iv_hist[s]) begin n_bad++;
        $display("FAIL bubble_pattern step %0d: got out_valid %b, expected %b", s + LAT, ov_hist[s+LAT], iv_hist[s]); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_known();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_bubbles();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
